// File: rtl/rx_frame_sink.sv
// rx_frame_sink: receive-side frame terminator. Delimits frames on the Rx byte
// stream, strips and checks the trailing CRC-8, forwards payload one beat late,
// and keeps saturating good/CRC/format counters.
module rx_frame_sink #(
    parameter int unsigned MAX_LEN  = 64,
    parameter logic [7:0]  CRC_POLY = 8'h07,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_1M024,
    input  logic             rst_n_1M024,
    input  logic [7:0]       data_tdata,
    input  logic             data_tvalid,
    input  logic             data_tuser,
    input  logic             data_tlast,
    output logic [7:0]       payload_tdata,
    output logic             payload_tvalid,
    output logic             payload_tuser,
    output logic             payload_tlast,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [7:0]       frame_len,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_crc_err,
    output logic [CNT_W-1:0] cnt_fmt_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_hold;
    logic [7:0] r_crc;
    logic [7:0] r_len;
    logic       r_first;

    state_t     w_state_nxt;
    logic [7:0] w_hold_nxt;
    logic [7:0] w_crc_nxt;
    logic [7:0] w_len_nxt;
    logic       w_first_nxt;
    logic [7:0] w_crc_fold;
    logic       w_start;
    logic       w_emit;
    logic       w_emit_last;
    logic       w_ok;
    logic       w_crc_err;
    logic       w_fmt_err;

    // One byte of MSB-first CRC-8, no reflection, no final XOR.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // CRC including the held byte, used both for folding and for the final compare.
    assign w_crc_fold = crc8_byte(r_crc, r_hold);

    // Next-state and per-beat decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_crc_nxt   = r_crc;
        w_len_nxt   = r_len;
        w_first_nxt = r_first;
        w_start     = 1'b0;
        w_emit      = 1'b0;
        w_emit_last = 1'b0;
        w_ok        = 1'b0;
        w_crc_err   = 1'b0;
        w_fmt_err   = 1'b0;

        if (data_tvalid) begin
            unique case (r_state)
                S_IDLE: begin
                    if (data_tuser) begin
                        if (data_tlast) w_fmt_err = 1'b1;
                        else            w_start   = 1'b1;
                    end else begin
                        w_fmt_err   = 1'b1;
                        w_state_nxt = data_tlast ? S_IDLE : S_DROP;
                    end
                end
                S_RECV: begin
                    if (data_tuser) begin
                        // Aborted frame: held byte is discarded, new frame may start.
                        w_fmt_err = 1'b1;
                        if (data_tlast) w_state_nxt = S_IDLE;
                        else            w_start     = 1'b1;
                    end else if (!data_tlast) begin
                        w_emit = 1'b1;
                        if (r_len >= 8'(MAX_LEN)) begin
                            w_fmt_err   = 1'b1;
                            w_state_nxt = S_DROP;
                        end else begin
                            w_crc_nxt  = w_crc_fold;
                            w_hold_nxt = data_tdata;
                            w_len_nxt  = r_len + 8'd1;
                        end
                    end else begin
                        w_emit      = 1'b1;
                        w_emit_last = 1'b1;
                        if (w_crc_fold == data_tdata) w_ok      = 1'b1;
                        else                          w_crc_err = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (data_tuser) begin
                        if (data_tlast) begin
                            w_fmt_err   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_start = 1'b1;
                        end
                    end else if (data_tlast) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        if (w_emit) w_first_nxt = 1'b0;

        if (w_start) begin
            w_state_nxt = S_RECV;
            w_hold_nxt  = data_tdata;
            w_crc_nxt   = 8'h00;
            w_len_nxt   = 8'd1;
            w_first_nxt = 1'b1;
        end
    end

    // State, frame context and registered outputs.
    always_ff @(posedge clk_1M024) begin
        if (!rst_n_1M024) begin
            r_state        <= S_IDLE;
            r_hold         <= 8'h00;
            r_crc          <= 8'h00;
            r_len          <= 8'h00;
            r_first        <= 1'b0;
            payload_tdata  <= 8'h00;
            payload_tvalid <= 1'b0;
            payload_tuser  <= 1'b0;
            payload_tlast  <= 1'b0;
            frame_ok       <= 1'b0;
            frame_err      <= 1'b0;
            frame_len      <= 8'h00;
            cnt_ok         <= '0;
            cnt_crc_err    <= '0;
            cnt_fmt_err    <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_hold         <= w_hold_nxt;
            r_crc          <= w_crc_nxt;
            r_len          <= w_len_nxt;
            r_first        <= w_first_nxt;
            payload_tvalid <= w_emit;
            payload_tuser  <= w_emit & r_first;
            payload_tlast  <= w_emit_last;
            frame_ok       <= w_ok;
            frame_err      <= w_crc_err | w_fmt_err;
            if (w_emit)      payload_tdata <= r_hold;
            if (w_emit_last) frame_len     <= r_len;
            if (w_ok && (cnt_ok != '1))           cnt_ok      <= cnt_ok + CNT_W'(1);
            if (w_crc_err && (cnt_crc_err != '1)) cnt_crc_err <= cnt_crc_err + CNT_W'(1);
            if (w_fmt_err && (cnt_fmt_err != '1)) cnt_fmt_err <= cnt_fmt_err + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rx_frame_sink.sv
// Bench for rx_frame_sink: table-driven beat vectors against a default instance
// and a small instance (MAX_LEN=4, CNT_W=2) for length and saturation corners.
module tb_rx_frame_sink;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sel;
    logic       in_v, in_u, in_l;
    logic [7:0] in_d;
    logic       a_v, b_v;

    assign a_v = in_v & ~sel;
    assign b_v = in_v & sel;

    logic [7:0]  a_pd, b_pd, a_len, b_len;
    logic        a_pv, a_pu, a_pl, a_ok, a_err;
    logic        b_pv, b_pu, b_pl, b_ok, b_err;
    logic [15:0] a_cok, a_ccrc, a_cfmt;
    logic [1:0]  b_cok, b_ccrc, b_cfmt;

    rx_frame_sink u_dut_a (
        .clk_1M024(clk), .rst_n_1M024(rst_n),
        .data_tdata(in_d), .data_tvalid(a_v), .data_tuser(in_u), .data_tlast(in_l),
        .payload_tdata(a_pd), .payload_tvalid(a_pv), .payload_tuser(a_pu), .payload_tlast(a_pl),
        .frame_ok(a_ok), .frame_err(a_err), .frame_len(a_len),
        .cnt_ok(a_cok), .cnt_crc_err(a_ccrc), .cnt_fmt_err(a_cfmt)
    );

    rx_frame_sink #(.MAX_LEN(4), .CRC_POLY(8'h07), .CNT_W(2)) u_dut_b (
        .clk_1M024(clk), .rst_n_1M024(rst_n),
        .data_tdata(in_d), .data_tvalid(b_v), .data_tuser(in_u), .data_tlast(in_l),
        .payload_tdata(b_pd), .payload_tvalid(b_pv), .payload_tuser(b_pu), .payload_tlast(b_pl),
        .frame_ok(b_ok), .frame_err(b_err), .frame_len(b_len),
        .cnt_ok(b_cok), .cnt_crc_err(b_ccrc), .cnt_fmt_err(b_cfmt)
    );

    typedef struct {
        logic       v, u, l;
        logic [7:0] d;
        logic       epv, epu, epl;
        logic [7:0] epd;
        logic       eok, eerr;
    } vec_t;

    vec_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic u, input logic l, input logic [7:0] d,
                       input logic epv, input logic epu, input logic epl, input logic [7:0] epd,
                       input logic eok, input logic eerr);
        vec_t r;
        r.v = v; r.u = u; r.l = l; r.d = d;
        r.epv = epv; r.epu = epu; r.epl = epl; r.epd = epd;
        r.eok = eok; r.eerr = eerr;
        q.push_back(r);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    endtask

    // Frame of n consecutive byte values starting at 'first', then CRC byte.
    task automatic add_frame(input logic [7:0] first, input int n, input logic [7:0] crc,
                             input logic good, input int gaps, input logic first_err);
        add(1, 1, 0, first, 0, 0, 0, 8'h00, 0, first_err);
        add_idle(gaps);
        for (int k = 1; k < n; k++) begin
            add(1, 0, 0, first + 8'(k), 1, (k == 1), 0, first + 8'(k - 1), 0, 0);
            add_idle(gaps);
        end
        add(1, 0, 1, crc, 1, (n == 1), 1, first + 8'(n - 1), good, !good);
        add_idle(gaps);
    endtask

    task automatic run_table(input string name);
        logic [12:0] act, exp;
        for (int i = 0; i < q.size(); i++) begin
            in_v = q[i].v; in_u = q[i].u; in_l = q[i].l; in_d = q[i].d;
            @(posedge clk);
            #1;
            if (sel) act = {b_pv, b_pu, b_pl, (b_pv ? b_pd : 8'h00), b_ok, b_err};
            else     act = {a_pv, a_pu, a_pl, (a_pv ? a_pd : 8'h00), a_ok, a_err};
            exp = {q[i].epv, q[i].epu, q[i].epl, (q[i].epv ? q[i].epd : 8'h00), q[i].eok, q[i].eerr};
            check($sformatf("%s[%0d]", name, i), 32'(act), 32'(exp));
        end
        in_v = 0; in_u = 0; in_l = 0; in_d = 8'h00;
        q.delete();
    endtask

    task automatic do_reset(input string name);
        in_v = 0; in_u = 0; in_l = 0; in_d = 8'h00;
        rst_n = 0;
        @(posedge clk);
        #1;
        check({name, "_a_out"}, 32'({a_pv, a_pu, a_pl, a_pd, a_ok, a_err}), 32'h0);
        check({name, "_a_len"}, 32'(a_len), 32'h0);
        check({name, "_a_cnt"}, 32'({a_cok, a_ccrc}), 32'h0);
        check({name, "_a_fmt"}, 32'(a_cfmt), 32'h0);
        check({name, "_b_out"}, 32'({b_pv, b_pu, b_pl, b_pd, b_ok, b_err, b_len}), 32'h0);
        check({name, "_b_cnt"}, 32'({b_cok, b_ccrc, b_cfmt}), 32'h0);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; sel = 0;
        in_v = 0; in_u = 0; in_l = 0; in_d = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset("rst0");

        // Two good frames back to back ("123456789" -> CRC 0xF4).
        add_frame(8'h31, 9, 8'hF4, 1, 0, 0);
        add_frame(8'h31, 9, 8'hF4, 1, 0, 0);
        add_idle(1);
        run_table("good");
        check("good_len", 32'(a_len), 32'd9);
        check("good_cok", 32'(a_cok), 32'd2);
        check("good_errs", 32'({a_ccrc, a_cfmt}), 32'h0);

        // Stray bytes ending with tlast, then an empty frame.
        add(1, 0, 0, 8'h55, 0, 0, 0, 8'h00, 0, 1);
        add(1, 0, 0, 8'h66, 0, 0, 0, 8'h00, 0, 0);
        add(1, 0, 1, 8'h77, 0, 0, 0, 8'h00, 0, 0);
        add(1, 1, 1, 8'h88, 0, 0, 0, 8'h00, 0, 1);
        add_idle(1);
        run_table("stray");
        check("stray_fmt", 32'(a_cfmt), 32'd2);
        check("stray_cok", 32'(a_cok), 32'd2);
        check("stray_len", 32'(a_len), 32'd9);

        // Reset in the middle of a frame while a payload beat is on the output.
        add(1, 1, 0, 8'h31, 0, 0, 0, 8'h00, 0, 0);
        add(1, 0, 0, 8'h32, 1, 1, 0, 8'h31, 0, 0);
        run_table("mid");
        do_reset("rst_mid");
        add_frame(8'h31, 9, 8'hF4, 1, 0, 0);
        add_idle(1);
        run_table("after_rst");
        check("after_rst_cok", 32'(a_cok), 32'd1);
        check("after_rst_fmt", 32'(a_cfmt), 32'd0);

        // Same frame with a wrong CRC byte.
        do_reset("rst_crc");
        add_frame(8'h31, 9, 8'hF5, 0, 0, 0);
        add_idle(1);
        run_table("badcrc");
        check("badcrc_crc", 32'(a_ccrc), 32'd1);
        check("badcrc_cok", 32'(a_cok), 32'd0);
        check("badcrc_len", 32'(a_len), 32'd9);

        // Aborted frame with idle gaps, then a good frame.
        do_reset("rst_abort");
        add(1, 1, 0, 8'h31, 0, 0, 0, 8'h00, 0, 0);
        add_idle(3);
        add(1, 0, 0, 8'h32, 1, 1, 0, 8'h31, 0, 0);
        add_idle(3);
        add_frame(8'h31, 9, 8'hF4, 1, 3, 1);
        run_table("abort");
        check("abort_fmt", 32'(a_cfmt), 32'd1);
        check("abort_cok", 32'(a_cok), 32'd1);

        // Small instance: overlength frame of 6 bytes with MAX_LEN=4.
        sel = 1;
        add(1, 1, 0, 8'h01, 0, 0, 0, 8'h00, 0, 0);
        add(1, 0, 0, 8'h02, 1, 1, 0, 8'h01, 0, 0);
        add(1, 0, 0, 8'h03, 1, 0, 0, 8'h02, 0, 0);
        add(1, 0, 0, 8'h04, 1, 0, 0, 8'h03, 0, 0);
        add(1, 0, 0, 8'h05, 1, 0, 0, 8'h04, 0, 1);
        add(1, 0, 0, 8'h06, 0, 0, 0, 8'h00, 0, 0);
        add(1, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
        add_idle(1);
        run_table("over");
        check("over_fmt", 32'(b_cfmt), 32'd1);
        check("over_len", 32'(b_len), 32'd0);

        // Frame {01,02} has CRC 0x1B; five of them saturate the 2-bit counter.
        add_frame(8'h01, 2, 8'h1B, 1, 0, 0);
        add_idle(1);
        run_table("small_good");
        check("small_cok1", 32'(b_cok), 32'd1);
        check("small_len", 32'(b_len), 32'd2);
        for (int f = 0; f < 4; f++) add_frame(8'h01, 2, 8'h1B, 1, 0, 0);
        add_idle(1);
        run_table("sat");
        check("sat_cok", 32'(b_cok), 32'd3);
        check("sat_other", 32'({b_ccrc, b_cfmt}), 32'({2'd0, 2'd1}));
        sel = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
